serial_add_ctrl: RTL and testbench

Bit-serial add/subtract sequencer that time-shares one 1-bit full-adder cell (two `halfadder` instances) across a WIDTH-bit operation, LSB first, one bit per clock. It sits between the ALU's operand registers and result bus as the low-area adder path. It accepts a request via a start/busy/done handshake, sequences the bit cell with a carry flop and shift registers, and returns sum, carry and signed-overflow flags.

---
 rtl/alu_pkg.sv | 13 +
 rtl/fulladder.sv | 39 +++
 rtl/serial_add_ctrl.sv | 103 ++++++++++
 tb/tb_serial_add_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: sequencer state encoding and add/sub opcodes.
package alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/fulladder.sv
// One-bit full adder built from two half adders; the only arithmetic
// in the serial add path.
module halfadder (
    input  logic i_a,
    input  logic i_b,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b;
    assign o_c = i_a & i_b;
endmodule

module fulladder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);
    logic w_s0;
    logic w_c0;
    logic w_c1;

    halfadder u_ha0 (
        .i_a (i_a),
        .i_b (i_b),
        .o_s (w_s0),
        .o_c (w_c0)
    );

    halfadder u_ha1 (
        .i_a (w_s0),
        .i_b (i_c),
        .o_s (o_s),
        .o_c (w_c1)
    );

    assign o_c = w_c0 | w_c1;
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: LSB first, one bit per clock,
// sharing a single full-adder cell across the whole operand width.
module serial_add_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;

    logic w_accept;
    logic w_last;
    logic w_s;
    logic w_c;

    assign w_accept = start &&
                      (r_state == ST_IDLE || r_state == ST_DONE);
    assign w_last   = (r_state == ST_RUN) && (r_cnt == LAST);

    fulladder u_fa (
        .i_a (r_a[0]),
        .i_b (r_b[0]),
        .i_c (r_carry),
        .o_s (w_s),
        .o_c (w_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: if (start)  w_next = ST_RUN;
            ST_RUN:  if (w_last) w_next = ST_DONE;
            ST_DONE: w_next = start ? ST_RUN : ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == ST_RUN);
        done = (r_state == ST_DONE);
    end

    // Subtraction is a + ~b + 1: the +1 enters through the carry flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            sum     <= '0;
            c_out   <= 1'b0;
            ovf     <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= (sub == OP_SUB) ? ~b : b;
            r_res   <= '0;
            r_carry <= (sub == OP_SUB);
            r_cnt   <= '0;
        end else if (r_state == ST_RUN) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_res   <= {w_s, r_res[WIDTH-1:1]};
            r_carry <= w_c;
            r_cnt   <= r_cnt + ONE;
            if (w_last) begin
                sum   <= {w_s, r_res[WIDTH-1:1]};
                c_out <= w_c;
                ovf   <= r_carry ^ w_c;
            end
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl at WIDTH=8.
module tb_serial_add_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         c_out;
    logic         ovf;

    int tests = 0;
    int fails = 0;
    logic [W-1:0] last_sum = '0;
    logic         last_c   = 1'b0;
    logic         last_v   = 1'b0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .c_out (c_out),
        .ovf   (ovf)
    );

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mode 0: start low during RUN, 1: start held high, 2: start pulses
    task automatic run_op(input string tag,
                          input logic [W-1:0] ia,
                          input logic [W-1:0] ib,
                          input logic isub,
                          input logic [W-1:0] es,
                          input logic ec,
                          input logic ev,
                          input int mode);
        @(negedge clk);
        start = 1'b1;
        a = ia;
        b = ib;
        sub = isub;
        @(posedge clk); #1;
        check({tag, " accept busy"}, busy, 1);
        check({tag, " accept done"}, done, 0);
        for (int k = 1; k <= W; k++) begin
            @(negedge clk);
            a = ia ^ W'(8'h5A + k);
            b = ib ^ W'(8'hC3 + k);
            sub = ~isub;
            if (mode == 1) start = 1'b1;
            else if (mode == 2) start = k[0];
            else start = 1'b0;
            @(posedge clk); #1;
            check({tag, " done"}, done, (k == W) ? 1 : 0);
            check({tag, " busy"}, busy, (k == W) ? 0 : 1);
            if (k != W) begin
                check({tag, " held sum"}, sum, last_sum);
                check({tag, " held c"}, c_out, last_c);
                check({tag, " held ovf"}, ovf, last_v);
            end
        end
        check({tag, " sum"}, sum, es);
        check({tag, " c_out"}, c_out, ec);
        check({tag, " ovf"}, ovf, ev);
        last_sum = es;
        last_c = ec;
        last_v = ev;
    endtask

    task automatic go_idle(input string tag);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        check({tag, " idle busy"}, busy, 0);
        check({tag, " idle done"}, done, 0);
        check({tag, " idle sum"}, sum, last_sum);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        sub = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset sum", sum, 0);
        check("reset c_out", c_out, 0);
        check("reset ovf", ovf, 0);
        @(negedge clk);
        rst = 1'b0;

        run_op("0f+01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 0);
        go_idle("0f+01");
        run_op("ff+01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0);
        go_idle("ff+01");
        run_op("7f+01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0);
        go_idle("7f+01");
        run_op("05-07", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, 0);
        go_idle("05-07");
        run_op("80-01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 0);
        go_idle("80-01");

        // back-to-back through DONE, start held and pulsed during RUN
        run_op("b2b 01+02", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, 1);
        run_op("b2b 03+04", 8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0, 2);
        run_op("b2b 10-30", 8'h10, 8'h30, 1'b1, 8'hE0, 1'b0, 1'b0, 1);
        go_idle("b2b");

        // reset in the 4th RUN cycle aborts with no done pulse
        @(negedge clk);
        start = 1'b1;
        a = 8'h55;
        b = 8'hAA;
        sub = 1'b0;
        @(posedge clk); #1;
        check("abort accept busy", busy, 1);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            start = 1'b0;
            @(posedge clk); #1;
            check("abort run busy", busy, 1);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort sum", sum, 0);
        check("abort c_out", c_out, 0);
        check("abort ovf", ovf, 0);
        @(negedge clk);
        rst = 1'b0;
        last_sum = '0;
        last_c = 1'b0;
        last_v = 1'b0;
        for (int k = 0; k < W + 2; k++) begin
            @(posedge clk); #1;
            check("abort no done", done, 0);
            check("abort no busy", busy, 0);
        end
        run_op("55+aa", 8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0, 1'b0, 0);
        go_idle("55+aa");

        // reset wins over a simultaneous start
        @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        a = 8'h12;
        b = 8'h34;
        @(posedge clk); #1;
        check("rst+start busy", busy, 0);
        check("rst+start done", done, 0);
        check("rst+start sum", sum, 0);
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;
        check("rst+start idle busy", busy, 0);
        check("rst+start idle done", done, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: run did not finish, required finish");
        $fatal(1, "timeout");
    end

endmodule
